blink_round_ctrl: RTL and testbench

Iterative round sequencer for the 128-bit Blink datapath. It accepts one plaintext or ciphertext block per transaction and holds it in a 128-bit state register. It then steps that register through ROUNDS applications of an external combinational round function (ShuffleCells or InvShuffleCells, S-layer and key addition, selected by direction) and returns the result over a valid/ready handshake. The block sits between the cipher top-level I/O and the round datapath; key scheduling is external and indexed by `round_idx`.

---
 rtl/blink_round_ctrl.sv | 107 ++++++++++
 tb/tb_blink_round_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_round_ctrl.sv
// blink_round_ctrl: iterative round sequencer for the 128-bit Blink datapath.
// Holds one block and steps it through ROUNDS passes of an external round function.
module blink_round_ctrl #(
    parameter int ROUNDS = 20,
    parameter int RW     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_dec,
    input  logic [127:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic [127:0]  round_in,
    input  logic [127:0]  round_out,
    output logic          round_dec,
    output logic [RW-1:0] round_idx,
    output logic          round_first,
    output logic          round_last,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

    state_t        state;
    state_t        state_n;
    logic [127:0]  blk;
    logic [RW-1:0] cnt;
    logic          dec;
    logic          accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    accept   = in_valid;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Reset wins over any handshake offered on the same edge.
        if (rst) begin
            in_ready = 1'b0;
            accept   = 1'b0;
        end
        if (accept) begin
            state_n = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk <= '0;
            cnt <= '0;
            dec <= 1'b0;
        end else if (accept) begin
            blk <= in_data;
            cnt <= '0;
            dec <= in_dec;
        end else if (state == RUN) begin
            blk <= round_out;
            if (cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign busy        = (state == RUN);
    assign out_valid   = (state == DONE);
    assign out_data    = blk;
    assign round_in    = blk;
    assign round_dec   = dec;
    assign round_idx   = dec ? (LAST - cnt) : cnt;
    assign round_first = busy && (cnt == '0);
    assign round_last  = busy && (cnt == LAST);

endmodule

// File: tb/tb_blink_round_ctrl.sv
// Randomized self-checking bench for blink_round_ctrl (ROUNDS=4 and ROUNDS=1 builds)
// using an additive stand-in round function and an arithmetic reference model.
module tb_blink_round_ctrl;

    localparam int R  = 4;
    localparam int RW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready, in_dec;
    logic [127:0]  in_data;
    logic          out_valid, out_ready;
    logic [127:0]  out_data, round_in, round_out;
    logic          round_dec, round_first, round_last, busy;
    logic [RW-1:0] round_idx;

    logic          in_valid1, in_ready1, in_dec1;
    logic [127:0]  in_data1;
    logic          out_valid1, out_ready1;
    logic [127:0]  out_data1, round_in1, round_out1;
    logic          round_dec1, round_first1, round_last1, busy1;
    logic [RW-1:0] round_idx1;

    assign round_out  = round_in + 128'({round_dec, round_idx});
    assign round_out1 = round_in1 + 128'({round_dec1, round_idx1});

    blink_round_ctrl #(.ROUNDS(R), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dec(in_dec), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data),
        .round_in(round_in), .round_out(round_out),
        .round_dec(round_dec), .round_idx(round_idx),
        .round_first(round_first), .round_last(round_last),
        .busy(busy)
    );

    blink_round_ctrl #(.ROUNDS(1), .RW(RW)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_dec(in_dec1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1),
        .round_in(round_in1), .round_out(round_out1),
        .round_dec(round_dec1), .round_idx(round_idx1),
        .round_first(round_first1), .round_last(round_last1),
        .busy(busy1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sum of per-round increments: each round adds 32*dec plus its round index.
    function automatic logic [127:0] ref_out(input logic [127:0] d,
                                             input logic dc, input int rounds);
        logic [127:0] acc;
        int k;
        acc = d;
        for (int r = 0; r < rounds; r++) begin
            k   = (dc ? 32 : 0) + (dc ? rounds - 1 - r : r);
            acc = acc + 128'(k);
        end
        return acc;
    endfunction

    task automatic send(input logic [127:0] d, input logic dc);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_dec   = dc;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("accept_timeout", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_dec   = 1'($urandom_range(0, 1));
    endtask

    task automatic expect_run(input logic [127:0] d, input logic dc);
        int idx;
        for (int r = 0; r < R; r++) begin
            idx = dc ? R - 1 - r : r;
            check("busy", 128'(busy), 128'(1));
            check("round_idx", 128'(round_idx), 128'(idx));
            check("round_first", 128'(round_first), 128'(r == 0));
            check("round_last", 128'(round_last), 128'(r == R - 1));
            check("in_ready_run", 128'(in_ready), 128'(0));
            check("out_valid_run", 128'(out_valid), 128'(0));
            check("round_dec", 128'(round_dec), 128'(dc));
            tick();
        end
        check("out_valid", 128'(out_valid), 128'(1));
        check("out_data", out_data, ref_out(d, dc, R));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [127:0] d;
        logic         dc;
        int           hold;

        rst = 1'b1;
        in_valid = 1'b1;
        in_dec = 1'b0;
        in_data = 128'h55;
        out_ready = 1'b1;
        in_valid1 = 1'b0;
        in_dec1 = 1'b0;
        in_data1 = '0;
        out_ready1 = 1'b1;
        tick();
        tick();
        check("in_ready_in_rst", 128'(in_ready), 128'(0));
        check("busy_in_rst", 128'(busy), 128'(0));
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_first", 128'(round_first), 128'(0));
        check("rst_last", 128'(round_last), 128'(0));
        check("rst_idx", 128'(round_idx), 128'(0));
        check("rst_dec", 128'(round_dec), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_round_in", round_in, 128'(0));

        // Encrypt single block
        send(128'h10, 1'b0);
        expect_run(128'h10, 1'b0);
        check("enc_out_data_const", out_data, 128'h16);
        tick();
        check("enc_idle_valid", 128'(out_valid), 128'(0));
        check("enc_idle_ready", 128'(in_ready), 128'(1));

        // Decrypt single block
        send(128'h0, 1'b1);
        expect_run(128'h0, 1'b1);
        check("dec_out_data_const", out_data, 128'h86);
        tick();

        // Backpressure, then back-to-back
        out_ready = 1'b0;
        send(128'h10, 1'b0);
        expect_run(128'h10, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 128'(out_valid), 128'(1));
            check("bp_data", out_data, 128'h16);
            check("bp_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 128'(in_ready), 128'(1));
        send(128'hABCD, 1'b1);
        expect_run(128'hABCD, 1'b1);
        tick();

        // Reset mid-RUN
        send(128'h1234, 1'b0);
        tick();
        tick();
        check("mid_idx", 128'(round_idx), 128'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mr_busy", 128'(busy), 128'(0));
        check("mr_out_valid", 128'(out_valid), 128'(0));
        check("mr_in_ready", 128'(in_ready), 128'(1));
        check("mr_idx", 128'(round_idx), 128'(0));
        send(128'h777, 1'b1);
        expect_run(128'h777, 1'b1);
        tick();

        // ROUNDS = 1 build
        in_valid1 = 1'b1;
        in_data1 = 128'h5;
        in_dec1 = 1'b0;
        #1;
        check("r1_in_ready", 128'(in_ready1), 128'(1));
        tick();
        in_valid1 = 1'b0;
        check("r1_busy", 128'(busy1), 128'(1));
        check("r1_first", 128'(round_first1), 128'(1));
        check("r1_last", 128'(round_last1), 128'(1));
        check("r1_idx", 128'(round_idx1), 128'(0));
        tick();
        check("r1_out_valid", 128'(out_valid1), 128'(1));
        check("r1_out_data", out_data1, ref_out(128'h5, 1'b0, 1));
        check("r1_out_data_const", out_data1, 128'h5);
        tick();
        check("r1_idle", 128'(out_valid1), 128'(0));

        // Randomized blocks with random backpressure and gaps
        for (int it = 0; it < 30; it++) begin
            d    = {$urandom, $urandom, $urandom, $urandom};
            dc   = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 3);
            send(d, dc);
            out_ready = (hold == 0);
            expect_run(d, dc);
            for (int h = 0; h < hold; h++) begin
                tick();
                check("rnd_hold_valid", 128'(out_valid), 128'(1));
                check("rnd_hold_data", out_data, ref_out(d, dc, R));
            end
            out_ready = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                tick();
                check("rnd_taken", 128'(out_valid), 128'(0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
